// File: rtl/huffman_pkg.sv
// -----------------------------------------------------------------------------
// huffman_pkg
//
// Shared definitions for the Huffman encoder and decoder datapaths.
//   BYTE_W         : width of one packed-code byte on the byte streams.
//   BIT_IDX_W      : width of a counter able to hold the value BYTE_W.
//   unpack_state_e : state encoding of the bit unpacker that feeds the
//                    decoder tree walker.
// -----------------------------------------------------------------------------
package huffman_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_IDX_W = $clog2(BYTE_W + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BYTE = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } unpack_state_e;

endpackage

// File: rtl/sync_flex_counter.sv
// -----------------------------------------------------------------------------
// sync_flex_counter
//
// Up-counter that stops at a programmable limit instead of wrapping.
//   clk          : clock, rising edge.
//   rst          : synchronous active-high reset, count to 0.
//   clear        : synchronous clear, count to 0 (beats count_enable).
//   count_enable : advance the count by one this cycle.
//   rollover_val : limit; the count holds once it reaches this value.
//   count_out    : current count.
// -----------------------------------------------------------------------------
module sync_flex_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [CNT_W-1:0] rollover_val,
    output logic [CNT_W-1:0] count_out
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (count_enable && (count_reg != rollover_val)) begin
            // Saturate at the limit so a stray enable can never wrap to 0.
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count_out = count_reg;

endmodule

// File: rtl/bit_unpacker.sv
// -----------------------------------------------------------------------------
// bit_unpacker
//
// Turns a stream of packed Huffman code bytes into a serial bit stream for the
// decoder tree walker, and ends the stream once the walker has reported the
// requested number of decoded symbols.
//
// Parameters
//   CNT_W     : width of the symbol count and of data_size.
//   MSB_FIRST : 1 = bit 7 of each byte is emitted first, 0 = bit 0 first.
// Ports
//   clk, rst              : clock and synchronous active-high reset.
//   clear                 : abort the current stream and return to IDLE.
//   start, data_size      : begin a stream of data_size symbols (IDLE only).
//   byte_valid/ready/data : packed-code byte input handshake.
//   bit_valid/ready/out   : serial bit output handshake.
//   symbol_done           : one-cycle pulse per symbol decoded by the walker.
//   sym_count             : symbols decoded in the current stream.
//   busy                  : stream in progress.
//   done                  : one-cycle end-of-stream pulse.
// -----------------------------------------------------------------------------
module bit_unpacker
    import huffman_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              start,
    input  logic [CNT_W-1:0]  data_size,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              bit_valid,
    output logic              bit_out,
    input  logic              bit_ready,
    input  logic              symbol_done,
    output logic [CNT_W-1:0]  sym_count,
    output logic              busy,
    output logic              done
);

    unpack_state_e        state_reg, state_next;
    logic [BYTE_W-1:0]    shift_reg, shift_next;
    logic [BIT_IDX_W-1:0] bit_idx_reg, bit_idx_next;
    logic [CNT_W-1:0]     size_reg, size_next;

    logic [BYTE_W-1:0]    load_byte;
    logic                 start_accept;
    logic                 byte_take;
    logic                 bit_take;
    logic                 last_symbol;

    // The shift register always shifts toward its MSB; for LSB-first order the
    // byte is mirrored on load so both orders share one shifter.
    genvar gi;
    generate
        for (gi = 0; gi < BYTE_W; gi++) begin : g_load_order
            if (MSB_FIRST != 0) begin : g_msb
                assign load_byte[gi] = byte_data[gi];
            end else begin : g_lsb
                assign load_byte[gi] = byte_data[BYTE_W-1-gi];
            end
        end
    endgenerate

    assign byte_ready = (state_reg == WAIT_BYTE);
    assign bit_valid  = (state_reg == SHIFT);
    assign bit_out    = bit_valid & shift_reg[BYTE_W-1];
    assign busy       = byte_ready | bit_valid;
    assign done       = (state_reg == DONE);

    assign start_accept = (state_reg == IDLE) & start & ~clear;
    assign byte_take    = byte_ready & byte_valid;
    assign bit_take     = bit_valid & bit_ready;

    // This symbol_done brings the count up to the latched size. The counter
    // registers the increment on the same edge the FSM moves to DONE.
    assign last_symbol = busy & symbol_done &
                         ((sym_count + CNT_W'(1)) == size_reg);

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        size_next    = size_reg;

        if (clear) begin
            // Abort: whatever byte is being offered or held is dropped.
            state_next   = IDLE;
            shift_next   = '0;
            bit_idx_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        size_next  = data_size;
                        state_next = (data_size == '0) ? DONE : WAIT_BYTE;
                    end
                end

                WAIT_BYTE: begin
                    if (last_symbol) begin
                        state_next = DONE;
                    end else if (byte_take) begin
                        shift_next   = load_byte;
                        bit_idx_next = BIT_IDX_W'(BYTE_W);
                        state_next   = SHIFT;
                    end
                end

                SHIFT: begin
                    if (bit_take) begin
                        shift_next   = {shift_reg[BYTE_W-2:0], 1'b0};
                        bit_idx_next = bit_idx_reg - BIT_IDX_W'(1);
                    end
                    if (last_symbol) begin
                        // Stream complete: the rest of the byte is padding.
                        // A bit taken in this same cycle still counts.
                        state_next   = DONE;
                        shift_next   = '0;
                        bit_idx_next = '0;
                    end else if (bit_take && (bit_idx_reg == BIT_IDX_W'(1))) begin
                        // Last bit of the byte taken; the next byte is only
                        // accepted from WAIT_BYTE, giving a one-cycle bubble.
                        state_next = WAIT_BYTE;
                    end
                end

                DONE: begin
                    state_next = IDLE;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            size_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            size_reg    <= size_next;
        end
    end

    // Only an accepted start restarts the count; start outside IDLE is ignored.
    sync_flex_counter #(
        .CNT_W(CNT_W)
    ) u_sym_counter (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear | start_accept),
        .count_enable (symbol_done & busy),
        .rollover_val (size_reg),
        .count_out    (sym_count)
    );

endmodule

// File: tb/tb_bit_unpacker.sv
// -----------------------------------------------------------------------------
// tb_bit_unpacker
//
// Directed bench for bit_unpacker. One instance uses MSB-first order, a second
// uses LSB-first order. Inputs change on the falling edge, outputs are
// compared 1 time unit later.
// -----------------------------------------------------------------------------
module tb_bit_unpacker;

    localparam int CNT_W = 16;

    typedef struct {
        logic             start;
        logic [CNT_W-1:0] size;
        logic             bvalid;
        logic [7:0]       bdata;
        logic             rdy;
        logic             sd;
        logic             e_byte_ready;
        logic             e_bit_valid;
        logic             e_bit_out;
        logic             e_busy;
        logic             e_done;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // MSB-first instance
    logic             m_clear = 1'b0, m_start = 1'b0;
    logic [CNT_W-1:0] m_data_size = '0;
    logic             m_byte_valid = 1'b0;
    logic [7:0]       m_byte_data = '0;
    logic             m_byte_ready, m_bit_valid, m_bit_out;
    logic             m_bit_ready = 1'b0, m_symbol_done = 1'b0;
    logic [CNT_W-1:0] m_sym_count;
    logic             m_busy, m_done;

    // LSB-first instance
    logic             l_clear = 1'b0, l_start = 1'b0;
    logic [CNT_W-1:0] l_data_size = '0;
    logic             l_byte_valid = 1'b0;
    logic [7:0]       l_byte_data = '0;
    logic             l_byte_ready, l_bit_valid, l_bit_out;
    logic             l_bit_ready = 1'b0, l_symbol_done = 1'b0;
    logic [CNT_W-1:0] l_sym_count;
    logic             l_busy, l_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bit_unpacker #(.CNT_W(CNT_W), .MSB_FIRST(1)) u_dut_msb (
        .clk(clk), .rst(rst), .clear(m_clear), .start(m_start),
        .data_size(m_data_size), .byte_valid(m_byte_valid),
        .byte_data(m_byte_data), .byte_ready(m_byte_ready),
        .bit_valid(m_bit_valid), .bit_out(m_bit_out), .bit_ready(m_bit_ready),
        .symbol_done(m_symbol_done), .sym_count(m_sym_count),
        .busy(m_busy), .done(m_done)
    );

    bit_unpacker #(.CNT_W(CNT_W), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rst(rst), .clear(l_clear), .start(l_start),
        .data_size(l_data_size), .byte_valid(l_byte_valid),
        .byte_data(l_byte_data), .byte_ready(l_byte_ready),
        .bit_valid(l_bit_valid), .bit_out(l_bit_out), .bit_ready(l_bit_ready),
        .symbol_done(l_symbol_done), .sym_count(l_sym_count),
        .busy(l_busy), .done(l_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic st, logic [CNT_W-1:0] sz, logic bv, logic [7:0] bd,
                                logic rdy, logic sd, logic ebr, logic ebv, logic ebo,
                                logic ebusy, logic edone, logic [CNT_W-1:0] ecnt);
        vec_t v;
        v.start = st; v.size = sz; v.bvalid = bv; v.bdata = bd; v.rdy = rdy; v.sd = sd;
        v.e_byte_ready = ebr; v.e_bit_valid = ebv; v.e_bit_out = ebo;
        v.e_busy = ebusy; v.e_done = edone; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic idle_m_inputs();
        m_start = 1'b0; m_data_size = '0; m_byte_valid = 1'b0; m_byte_data = '0;
        m_bit_ready = 1'b0; m_symbol_done = 1'b0; m_clear = 1'b0;
    endtask

    task automatic check_m_all_zero(input string tag);
        chk({tag, "_byte_ready"}, 32'(m_byte_ready), 32'd0);
        chk({tag, "_bit_valid"},  32'(m_bit_valid),  32'd0);
        chk({tag, "_bit_out"},    32'(m_bit_out),    32'd0);
        chk({tag, "_busy"},       32'(m_busy),       32'd0);
        chk({tag, "_done"},       32'(m_done),       32'd0);
        chk({tag, "_sym_count"},  32'(m_sym_count),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[14];
        logic       got[16];
        logic [7:0] bytes[2];
        logic [3:0] pat;
        logic [15:0] exp16;
        logic [7:0] exp8;
        int         nbits, acc, done_seen;
        logic       held_bit, have_held;

        // data_size=3, bytes 0xB4 then 0x00, bit_ready always 1; symbol_done
        // together with bits 1, 3 and 6; a start in SHIFT must be ignored.
        // Then a zero-size stream, and symbol_done in DONE/IDLE is ignored.
        vecs[0]  = mk(1, 3, 0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 8'hB4, 1, 0,  1, 0, 0, 1, 0, 0);
        vecs[2]  = mk(0, 0, 1, 8'h00, 1, 1,  0, 1, 1, 1, 0, 0);
        vecs[3]  = mk(1, 9, 1, 8'h00, 1, 0,  0, 1, 0, 1, 0, 1);
        vecs[4]  = mk(0, 0, 1, 8'h00, 1, 1,  0, 1, 1, 1, 0, 1);
        vecs[5]  = mk(0, 0, 1, 8'h00, 1, 0,  0, 1, 1, 1, 0, 2);
        vecs[6]  = mk(0, 0, 1, 8'h00, 1, 0,  0, 1, 0, 1, 0, 2);
        vecs[7]  = mk(0, 0, 1, 8'h00, 1, 1,  0, 1, 1, 1, 0, 2);
        vecs[8]  = mk(0, 0, 1, 8'h00, 1, 0,  0, 0, 0, 0, 1, 3);
        vecs[9]  = mk(0, 0, 0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 3);
        vecs[10] = mk(1, 0, 0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 3);
        vecs[11] = mk(0, 0, 1, 8'h55, 0, 1,  0, 0, 0, 0, 1, 0);
        vecs[12] = mk(0, 0, 1, 8'h55, 0, 1,  0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0);

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_m_all_zero("reset");
        chk("reset_lsb_byte_ready", 32'(l_byte_ready), 32'd0);
        chk("reset_lsb_bit_valid",  32'(l_bit_valid),  32'd0);
        chk("reset_lsb_sym_count",  32'(l_sym_count),  32'd0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 14; i++) begin
            if (i != 0) @(negedge clk);
            m_start = vecs[i].start; m_data_size = vecs[i].size;
            m_byte_valid = vecs[i].bvalid; m_byte_data = vecs[i].bdata;
            m_bit_ready = vecs[i].rdy; m_symbol_done = vecs[i].sd;
            #1;
            $display("vec %0d: start=%0b size=%0d bv=%0b bd=%02h rdy=%0b sd=%0b -> br=%0b bvalid=%0b bit=%0b busy=%0b done=%0b cnt=%0d",
                     i, vecs[i].start, vecs[i].size, vecs[i].bvalid, vecs[i].bdata,
                     vecs[i].rdy, vecs[i].sd, m_byte_ready, m_bit_valid, m_bit_out,
                     m_busy, m_done, m_sym_count);
            chk($sformatf("vec%0d_byte_ready", i), 32'(m_byte_ready), 32'(vecs[i].e_byte_ready));
            chk($sformatf("vec%0d_bit_valid", i),  32'(m_bit_valid),  32'(vecs[i].e_bit_valid));
            chk($sformatf("vec%0d_bit_out", i),    32'(m_bit_out),    32'(vecs[i].e_bit_out));
            chk($sformatf("vec%0d_busy", i),       32'(m_busy),       32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_done", i),       32'(m_done),       32'(vecs[i].e_done));
            chk($sformatf("vec%0d_sym_count", i),  32'(m_sym_count),  32'(vecs[i].e_cnt));
        end
        @(negedge clk);
        idle_m_inputs();

        // ---------------- 16-bit stream with bit_ready 1,0,0,1 ----------------
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; exp16 = 16'hA53C;
        pat = 4'b1001;  // pat[k%4] gives 1,0,0,1
        m_start = 1'b1; m_data_size = 16'd100;
        @(negedge clk);
        m_start = 1'b0;
        nbits = 0; acc = 0; have_held = 1'b0; held_bit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k != 0) @(negedge clk);
            m_bit_ready  = pat[k % 4];
            m_byte_valid = (acc < 2);
            m_byte_data  = (acc < 2) ? bytes[acc] : 8'h00;
            #1;
            if (have_held && m_bit_valid)
                chk("stall_hold_bit_out", 32'(m_bit_out), 32'(held_bit));
            have_held = 1'b0;
            if (m_byte_ready && m_byte_valid) begin
                $display("stream byte %0d accepted: %02h", acc, m_byte_data);
                acc++;
            end
            if (m_bit_valid && m_bit_ready) begin
                got[nbits] = m_bit_out;
                $display("stream bit %0d = %0b", nbits, m_bit_out);
                nbits++;
            end else if (m_bit_valid) begin
                held_bit  = m_bit_out;
                have_held = 1'b1;
            end
            if (nbits == 16) break;
        end
        chk("stream_bit_count", 32'(nbits), 32'd16);
        for (int i = 0; i < 16; i++)
            if (i < nbits) chk($sformatf("stream_bit%0d", i), 32'(got[i]), 32'(exp16[15-i]));
        @(negedge clk);
        idle_m_inputs();
        m_clear = 1'b1;
        @(negedge clk);
        m_clear = 1'b0;

        // ---------------- clear in SHIFT with sym_count=5 ----------------
        m_start = 1'b1; m_data_size = 16'd20;
        @(negedge clk);
        m_start = 1'b0; m_byte_valid = 1'b1; m_byte_data = 8'hFF;
        @(negedge clk);
        m_byte_valid = 1'b0; m_bit_ready = 1'b0; m_symbol_done = 1'b1;
        repeat (4) @(negedge clk);
        @(negedge clk);
        m_clear = 1'b1;  // symbol_done still high: clear must win
        #1;
        chk("clear_pre_bit_valid", 32'(m_bit_valid), 32'd1);
        chk("clear_pre_sym_count", 32'(m_sym_count), 32'd5);
        @(negedge clk);
        m_clear = 1'b0; m_symbol_done = 1'b0;
        #1;
        $display("clear applied: busy=%0b cnt=%0d done=%0b", m_busy, m_sym_count, m_done);
        check_m_all_zero("clear_post");
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (m_done) done_seen++;
        end
        chk("clear_no_done", 32'(done_seen), 32'd0);

        // restart with data_size=2 after the clear
        m_start = 1'b1; m_data_size = 16'd2;
        @(negedge clk);
        m_start = 1'b0; m_byte_valid = 1'b1; m_byte_data = 8'hC0;
        @(negedge clk);
        m_byte_valid = 1'b0; m_bit_ready = 1'b1; m_symbol_done = 1'b1;
        #1;
        chk("restart_bit1", 32'(m_bit_out), 32'd1);
        @(negedge clk);
        #1;
        chk("restart_bit2", 32'(m_bit_out), 32'd1);
        chk("restart_cnt_mid", 32'(m_sym_count), 32'd1);
        @(negedge clk);
        m_symbol_done = 1'b0; m_bit_ready = 1'b0;
        #1;
        $display("restart end: done=%0b cnt=%0d", m_done, m_sym_count);
        chk("restart_done", 32'(m_done), 32'd1);
        chk("restart_bit_valid", 32'(m_bit_valid), 32'd0);
        chk("restart_sym_count", 32'(m_sym_count), 32'd2);
        @(negedge clk);
        #1;
        chk("restart_done_pulse_width", 32'(m_done), 32'd0);
        chk("restart_hold_count", 32'(m_sym_count), 32'd2);

        // ---------------- rst mid-stream ----------------
        m_start = 1'b1; m_data_size = 16'd10;
        @(negedge clk);
        m_start = 1'b0; m_byte_valid = 1'b1; m_byte_data = 8'h0F;
        @(negedge clk);
        m_byte_valid = 1'b0; m_symbol_done = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_pre_sym_count", 32'(m_sym_count), 32'd1);
        chk("rst_pre_bit_valid", 32'(m_bit_valid), 32'd1);
        rst = 1'b1; m_symbol_done = 1'b1; m_byte_valid = 1'b1; m_bit_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_m_inputs();
        #1;
        $display("rst applied: busy=%0b cnt=%0d done=%0b", m_busy, m_sym_count, m_done);
        check_m_all_zero("rst_mid");
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (m_done) done_seen++;
        end
        chk("rst_no_done", 32'(done_seen), 32'd0);

        // ---------------- LSB-first instance, byte 0xB4 ----------------
        exp8 = 8'h2D;  // 0xB4 mirrored: bits 0,0,1,0,1,1,0,1
        l_start = 1'b1; l_data_size = 16'd1;
        @(negedge clk);
        l_start = 1'b0; l_byte_valid = 1'b1; l_byte_data = 8'hB4;
        nbits = 0;
        for (int k = 0; k < 20; k++) begin
            if (k != 0) @(negedge clk);
            l_bit_ready = 1'b1;
            #1;
            if (l_byte_ready && l_byte_valid && (k > 0)) l_byte_valid = 1'b0;
            if (l_bit_valid && l_bit_ready) begin
                l_byte_valid = 1'b0;
                got[nbits] = l_bit_out;
                $display("lsb bit %0d = %0b", nbits, l_bit_out);
                nbits++;
            end
            if (nbits == 8) break;
        end
        chk("lsb_bit_count", 32'(nbits), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < nbits) chk($sformatf("lsb_bit%0d", i), 32'(got[i]), 32'(exp8[7-i]));
        @(negedge clk);
        l_bit_ready = 1'b0; l_byte_valid = 1'b0;
        #1;
        chk("lsb_back_to_wait_byte", 32'(l_byte_ready), 32'd1);
        chk("lsb_bit_valid_bubble", 32'(l_bit_valid), 32'd0);
        l_clear = 1'b1;
        @(negedge clk);
        l_clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
